// File: rtl/intpol2_d4_out_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : intpol2_d4_out_stream_pkg                                 |
// | Brief    : Shared defaults and entry-width helper for the output     |
// |            stream FIFO of the D4 interpolator.                       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package intpol2_d4_out_stream_pkg;

  localparam int C_DATAPATH_WIDTH_DEF = 32;
  localparam int C_CONFIG_WIDTH_DEF   = 32;
  localparam int C_DEPTH_LOG2_DEF     = 4;
  localparam int C_AFULL_MARGIN_DEF   = 4;

  // A RAM entry is {last, data}: one frame-marker bit on top of the sample.
  localparam int C_ENTRY_WIDTH_DEF    = C_DATAPATH_WIDTH_DEF + 1;

  function automatic int entry_width(input int datapath_width);
    return datapath_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intpol2_d4_out_stream_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : intpol2_d4_out_stream_if                                  |
// | Brief    : AXI4-Stream style master/slave bundle (data, valid,       |
// |            ready, last) for the interpolator output stream.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface intpol2_d4_out_stream_if
  import intpol2_d4_out_stream_pkg::*;
#(
  parameter int DATAPATH_WIDTH = C_DATAPATH_WIDTH_DEF
) ();

  logic [DATAPATH_WIDTH-1:0] tdata;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/intpol2_d4_out_stream_sync_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : intpol2_d4_out_stream_sync_ram                            |
// | Brief    : Simple dual-port RAM, registered write, asynchronous read.|
// |            Contents are not reset.                                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module intpol2_d4_out_stream_sync_ram
  import intpol2_d4_out_stream_pkg::*;
#(
  parameter int WIDTH      = C_ENTRY_WIDTH_DEF,
  parameter int ADDR_WIDTH = C_DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

  // Write port: one entry per enabled clock edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/intpol2_d4_out_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : intpol2_d4_out_stream                                     |
// | Brief    : Output FIFO of the D4 interpolator. Tags each written     |
// |            sample with a frame-last bit, buffers it in RAM and       |
// |            presents it on a registered stream head.                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module intpol2_d4_out_stream
  import intpol2_d4_out_stream_pkg::*;
#(
  parameter int DATAPATH_WIDTH = C_DATAPATH_WIDTH_DEF,
  parameter int CONFIG_WIDTH   = C_CONFIG_WIDTH_DEF,
  parameter int DEPTH_LOG2     = C_DEPTH_LOG2_DEF,
  parameter int AFULL_MARGIN   = C_AFULL_MARGIN_DEF
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [DATAPATH_WIDTH-1:0]  wr_data,
  input  logic [CONFIG_WIDTH-1:0]    ilen,
  output logic                       Afull,
  output logic                       full,
  output logic [DEPTH_LOG2:0]        level,
  intpol2_d4_out_stream_if.master    m_axis,
  output logic                       ovf,
  output logic                       frame_done
);

  localparam int DEPTH       = 1 << DEPTH_LOG2;
  localparam int ENTRY_WIDTH = entry_width(DATAPATH_WIDTH);
  localparam int LEVEL_WIDTH = DEPTH_LOG2 + 1;

  localparam logic [LEVEL_WIDTH-1:0]  C_DEPTH        = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0]  C_AFULL_THRESH = LEVEL_WIDTH'(DEPTH - AFULL_MARGIN);
  localparam logic [CONFIG_WIDTH-1:0] C_ONE          = CONFIG_WIDTH'(1);

  logic [DEPTH_LOG2-1:0]     r_wr_ptr;
  logic [DEPTH_LOG2-1:0]     r_rd_ptr;
  logic [LEVEL_WIDTH-1:0]    r_level;
  logic [CONFIG_WIDTH-1:0]   r_wr_cnt;
  logic                      r_out_valid;
  logic                      r_out_last;
  logic [DATAPATH_WIDTH-1:0] r_out_data;
  logic                      r_ovf;
  logic                      r_frame_done;

  logic                      w_full;
  logic                      w_wr_acc;
  logic                      w_wr_drop;
  logic                      w_pop;
  logic                      w_hs;
  logic [CONFIG_WIDTH-1:0]   w_ilen_eff;
  logic                      w_wr_last;
  logic [ENTRY_WIDTH-1:0]    w_rd_entry;

  // Flags come straight from the RAM occupancy; the head register is not counted.
  assign w_full    = (r_level == C_DEPTH);
  assign w_wr_acc  = wr_en & ~w_full;
  assign w_wr_drop = wr_en & w_full;

  // ilen = 0 behaves as a one-sample frame.
  assign w_ilen_eff = (ilen == '0) ? C_ONE : ilen;
  assign w_wr_last  = (r_wr_cnt == (w_ilen_eff - C_ONE));

  // Refill the head when it is empty or being consumed, and RAM has data.
  assign w_hs  = r_out_valid & m_axis.tready;
  assign w_pop = (~r_out_valid | m_axis.tready) & (r_level != '0);

  intpol2_d4_out_stream_sync_ram #(
    .WIDTH      (ENTRY_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_wr_acc),
    .wr_addr (r_wr_ptr),
    .wr_data ({w_wr_last, wr_data}),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_entry)
  );

  // RAM bookkeeping: pointers, occupancy and per-frame write counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_wr_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_wr_cnt <= w_wr_last ? '0 : (r_wr_cnt + C_ONE);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Stream head register: loads from RAM, empties after a handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (clear) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_last  <= w_rd_entry[ENTRY_WIDTH-1];
      r_out_data  <= w_rd_entry[DATAPATH_WIDTH-1:0];
    end else if (w_hs) begin
      r_out_valid <= 1'b0;
    end
  end

  // Status: sticky overflow and a one-cycle pulse for the accepted last beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (clear) begin
      r_ovf        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_wr_drop) begin
        r_ovf <= 1'b1;
      end
      r_frame_done <= w_hs & r_out_last;
    end
  end

  assign Afull         = (r_level >= C_AFULL_THRESH);
  assign full          = w_full;
  assign level         = r_level;
  assign ovf           = r_ovf;
  assign frame_done    = r_frame_done;
  assign m_axis.tvalid = r_out_valid;
  assign m_axis.tlast  = r_out_last;
  assign m_axis.tdata  = r_out_data;

endmodule
`default_nettype wire
